uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: log2 of FIFO depth (16 entries); legal range 2..8.
REQ-002 Parameter IRQ_THRESH, default 1: occupancy at or above which rx_irq asserts; legal range 1..2^DEPTH_LOG2.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 rx_end  in  1  one-cycle pulse from the UART receiver: a byte completed with a valid stop bit.
REQ-006 rx_data  in  8  received byte; valid in the cycle rx_end=1.
REQ-007 rd_en  in  1  consumer pop request.
REQ-008 flush  in  1  discard all stored bytes.
REQ-009 ovf_clr  in  1  clear the sticky overflow flag.
REQ-010 rd_data  out  8  head-of-FIFO byte (first-word-fall-through).
REQ-011 empty  out  1  FIFO holds 0 bytes.
REQ-012 full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-013 count  out  DEPTH_LOG2+1  current occupancy.
REQ-014 ovf  out  1  sticky flag: at least one byte was dropped.
REQ-015 rx_irq  out  1  level interrupt: count >= IRQ_THRESH.

Function
REQ-016 Storage is a circular buffer of 2^DEPTH_LOG2 x 8 bits, addressed by a write pointer and a read pointer, each DEPTH_LOG2 bits wide and wrapping modulo depth.
REQ-017 A write occurs when rx_end=1 and (full=0, or a pop occurs in the same cycle); rx_data is stored at the write pointer, which then increments.
REQ-018 A pop occurs when rd_en=1 and empty=0; the read pointer increments; rd_en while empty is ignored with no state change.
REQ-019 rd_data equals the entry at the read pointer whenever empty=0; the value is a don't-care while empty=1.
REQ-020 A write becomes visible on the next edge: empty deasserts and rd_data shows the byte one cycle after the rx_end pulse (write-to-read latency 1 cycle).
REQ-021 count is registered: it increments on write only, decrements on pop only, and is unchanged on simultaneous write and pop.
REQ-022 empty = (count==0) and full = (count==2^DEPTH_LOG2); both are derived from the count register.
REQ-023 Full with simultaneous rx_end and rd_en: both operations occur, count stays at maximum, ovf is not set.
REQ-024 Empty with simultaneous rx_end and rd_en: only the write occurs, count becomes 1.
REQ-025 Overflow: rx_end=1, full=1 and no pop; the byte is dropped, pointers and count are unchanged, and ovf is set on the next edge.
REQ-026 ovf stays at 1 until ovf_clr=1; if ovf_clr and a new overflow occur in the same cycle, set wins and ovf stays 1.
REQ-027 flush=1 zeroes both pointers and count on the next edge; it overrides any write or pop in the same cycle; ovf is unaffected.
REQ-028 rx_irq is combinational from the count register: 1 iff count >= IRQ_THRESH.
REQ-029 The block has no dependence on receiver timing: back-to-back rx_end pulses on consecutive cycles are each accepted subject to REQ-017.

Reset
REQ-030 With reset=0 at a clk edge: pointers=0, count=0, ovf=0; hence empty=1, full=0, rx_irq=0.
REQ-031 Storage array contents are not reset; rd_data is undefined until the first write.
REQ-032 Reset overrides every other input in the same cycle, including mid-burst writes and pops.

Verification
REQ-033 Reset, then rx_end with rx_data=0x55 -> next cycle: empty=0, count=1, rd_data=0x55, rx_irq=1 (IRQ_THRESH=1).
REQ-034 Write 16 bytes 0x00..0x0F, then write 0xAA -> full=1, count=16, ovf=1, 0xAA dropped; 16 pops return 0x00..0x0F in order, then empty=1.
REQ-035 While full, rx_end=0x77 together with rd_en -> count stays 16, ovf stays 0; after draining, the last byte read is 0x77.
REQ-036 Write 24 / pop 24 interleaved so the pointers wrap -> read order matches write order and count never exceeds 16.
REQ-037 With ovf=1, drive ovf_clr and a new overflow in the same cycle -> ovf=1; ovf_clr alone next cycle -> ovf=0.
REQ-038 count=5, assert flush together with rx_end -> next cycle count=0, empty=1; reset=0 asserted mid-burst -> count=0 and ovf=0 next edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver.
// First-word-fall-through read side, sticky overflow flag, level interrupt.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_end,
    input  logic [7:0]            rx_data,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    output logic                  rx_irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] THRESH = (DEPTH_LOG2 + 1)'(IRQ_THRESH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  pop;
    logic                  wr;
    logic                  drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    always_comb begin
        pop  = rd_en & ~empty;
        wr   = rx_end & (~full | pop);
        drop = rx_end & full & ~pop;
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rx_irq  = (count >= THRESH);
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy; flush discards contents but not the ovf history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !wr) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky overflow: a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (reset && !flush && wr) begin
            mem[wr_ptr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo.
// Queue-based reference model, decoupled driver / model / monitor.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int IRQ_THRESH = 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                rx_end = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                rd_en = 1'b0;
    logic                flush = 1'b0;
    logic                ovf_clr = 1'b0;
    logic [7:0]          rd_data;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                ovf;
    logic                rx_irq;

    int       n_cmp = 0;
    int       n_err = 0;
    bit       armed = 1'b0;
    int       m_cnt = 0;
    bit       m_ovf = 1'b0;
    bit       m_pop;
    bit       m_acc;
    bit       m_drop;
    bit [7:0] sbq[$];
    int       max_cnt = 0;

    uart_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .IRQ_THRESH(IRQ_THRESH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_end(rx_end),
        .rx_data(rx_data),
        .rd_en(rd_en),
        .flush(flush),
        .ovf_clr(ovf_clr),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .count(count),
        .ovf(ovf),
        .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Reference decisions for the current cycle's inputs.
    assign m_pop  = rd_en && (m_cnt > 0);
    assign m_acc  = rx_end && ((m_cnt < DEPTH) || m_pop);
    assign m_drop = rx_end && !m_acc;

    // Reference model: occupancy, sticky flag and expected byte stream.
    always @(posedge clk) begin
        if (!reset) begin
            m_cnt <= 0;
            m_ovf <= 1'b0;
            sbq.delete();
        end else begin
            if (m_drop) m_ovf <= 1'b1;
            else if (ovf_clr) m_ovf <= 1'b0;
            if (flush) begin
                m_cnt <= 0;
                sbq.delete();
            end else begin
                m_cnt <= m_cnt + int'(m_acc) - int'(m_pop);
                if (m_acc) sbq.push_back(rx_data);
            end
        end
    end

    // Monitor: status every cycle, data on every accepted pop.
    always @(negedge clk) begin
        if (armed) begin
            if (m_cnt > max_cnt) max_cnt = m_cnt;
            chk("count", 32'(count), 32'(m_cnt));
            chk("empty", 32'(empty), 32'(m_cnt == 0));
            chk("full", 32'(full), 32'(m_cnt == DEPTH));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("rx_irq", 32'(rx_irq), 32'(m_cnt >= IRQ_THRESH));
            if (reset && !flush && m_pop) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(sbq.pop_front()));
                end
            end
        end
    end

    task automatic step(input bit re, input bit [7:0] d, input bit rd,
                        input bit fl, input bit oc, input bit rs);
        rx_end  = re;
        rx_data = d;
        rd_en   = rd;
        flush   = fl;
        ovf_clr = oc;
        reset   = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        armed = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // single byte, pop while empty, empty write+pop
        wr(8'h55);
        idle();
        rd();
        rd();
        step(1'b1, 8'h3c, 1'b1, 1'b0, 1'b0, 1'b1);
        rd();
        // fill, overflow drop, drain in order
        for (int i = 0; i < 16; i++) wr(8'(i));
        wr(8'haa);
        idle();
        for (int i = 0; i < 16; i++) rd();
        idle();
        // clear racing a new overflow, then clear alone
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
        step(1'b1, 8'hbb, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        // full with simultaneous write and pop
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        for (int i = 0; i < 16; i++) rd();
        idle();
        // pointer wrap: 24 writes interleaved with 24 pops
        for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
        for (int i = 8; i < 24; i++)
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) rd();
        idle();
        chk("max_count", 32'(max_cnt <= DEPTH), 32'd1);
        // flush overrides a write at count 5
        for (int i = 0; i < 5; i++) wr(8'(8'hc0 + i));
        step(1'b1, 8'hee, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        wr(8'h12);
        idle();
        rd();
        // reset mid-burst clears count and ovf
        for (int i = 0; i < 17; i++) wr(8'(8'hd0 + i));
        wr(8'hd7);
        step(1'b1, 8'he1, 1'b1, 1'b0, 1'b0, 1'b0);
        wr(8'he2);
        idle();
        rd();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 2) == 0, 8'($urandom),
                 ($urandom % 5) < 2, ($urandom % 64) == 0,
                 ($urandom % 16) == 0, ($urandom % 256) != 0);
        end
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
